// File: rtl/avr_spi_pkg.sv
// Shared types and helpers for the AVR-side ADC sample SPI master.
package avr_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_e;

  localparam int FRAME_BITS = 16;

  // Byte 0 carries sample[7:0]; byte 1 carries the channel tag and sample[9:8].
  function automatic logic [FRAME_BITS-1:0] pack_sample(input logic [9:0] sample,
                                                        input logic [3:0] channel);
    return {sample[7:0], channel, 2'b00, sample[9:8]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period divider: toggles sck every CLK_DIV enabled cycles, parks low when disabled.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          wrap;

  // rise/fall flag the clk edge on which sck_q itself changes.
  assign wrap = en && (div_q == DIV_LAST);
  assign rise = wrap && !sck_q;
  assign fall = wrap && sck_q;
  assign sck  = sck_q;

  always_comb begin
    div_d = '0;
    sck_d = 1'b0;
    if (en) begin
      div_d = wrap ? '0 : div_q + 1'b1;
      sck_d = wrap ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/avr_adc_spi_master.sv
// Mode-0 SPI master sending 10-bit ADC samples as a two-byte frame, capturing MISO bytes.
module avr_adc_spi_master
  import avr_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sample,
  input  logic [3:0] sample_channel,
  input  logic       new_sample,
  output logic       busy,
  output logic       spi_ss,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_done
);

  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(SS_GAP + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP - 1);

  state_e                state_q, state_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [4:0]            bit_q, bit_d;
  logic [FRAME_BITS-2:0] tx_q, tx_d;
  logic [6:0]            rx_sr_q, rx_sr_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  new_rx_q, new_rx_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  ss_q, ss_d;
  logic                  mosi_q, mosi_d;
  logic [FRAME_BITS-1:0] frame;
  logic                  sck_en, sck_rise, sck_fall;

  assign frame  = pack_sample(sample, sample_channel);
  assign sck_en = (state_q == XFER);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sck_en),
    .sck  (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    gap_d     = gap_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    new_rx_d  = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      IDLE: begin
        if (new_sample && !busy_q) begin
          tx_d    = frame[FRAME_BITS-2:0];
          mosi_d  = frame[FRAME_BITS-1];
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          ph_d    = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          state_d = XFER;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      XFER: begin
        if (sck_rise) begin
          rx_sr_d = {rx_sr_q[5:0], spi_miso};
          bit_d   = bit_q + 1'b1;
          // Every 8th rising edge completes a byte.
          if (bit_q[2:0] == 3'd7) begin
            rx_data_d = {rx_sr_q, spi_miso};
            new_rx_d  = 1'b1;
          end
        end
        if (sck_fall) begin
          tx_d   = {tx_q[FRAME_BITS-3:0], 1'b0};
          mosi_d = tx_q[FRAME_BITS-2];
          if (bit_q == 5'(FRAME_BITS)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          ss_d    = 1'b1;
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= 8'h00;
      new_rx_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      new_rx_q  <= new_rx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
    end
  end

  assign busy        = busy_q;
  assign spi_ss      = ss_q;
  assign spi_mosi    = mosi_q;
  assign rx_data     = rx_data_q;
  assign new_rx_data = new_rx_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_avr_adc_spi_master.sv
// Directed bench for avr_adc_spi_master with an SPI slave / AVR-decoder model on the bus.
module tb_avr_adc_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] sample = '0;
  logic [3:0] sample_channel = '0;
  logic       new_sample = 1'b0;
  logic       busy, spi_ss, spi_sck, spi_mosi;
  logic       spi_miso = 1'b0;
  logic [7:0] rx_data;
  logic       new_rx_data, frame_done;

  int checks = 0;
  int errors = 0;

  // bus monitor state
  logic        prev_sck = 1'b0;
  logic        prev_ss = 1'b1;
  logic [15:0] mosi_bits;
  logic [15:0] miso_pat = {8'h5C, 8'hE1};
  int          rises, ss_low_cnt, busy_cnt, done_cnt, nrx_cnt, gap_cnt, dec_pulses;
  logic [7:0]  rx_at8, rx_at16;
  logic        nrx_at8, nrx_at16;

  avr_adc_spi_master #(
    .CLK_DIV(4),
    .SS_GAP (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample        (sample),
    .sample_channel(sample_channel),
    .new_sample    (new_sample),
    .busy          (busy),
    .spi_ss        (spi_ss),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .rx_data       (rx_data),
    .new_rx_data   (new_rx_data),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mosi_bits  = '0;
    rises      = 0;
    ss_low_cnt = 0;
    busy_cnt   = 0;
    done_cnt   = 0;
    nrx_cnt    = 0;
    gap_cnt    = 0;
    dec_pulses = 0;
    rx_at8     = '0;
    rx_at16    = '0;
    nrx_at8    = 1'b0;
    nrx_at16   = 1'b0;
  endtask

  // One clk cycle: observe on the falling edge, then drive MISO like a mode-0 slave.
  task automatic step();
    @(negedge clk);
    if (spi_sck && !prev_sck) begin
      mosi_bits = {mosi_bits[14:0], spi_mosi};
      rises++;
      if (rises == 8) begin
        rx_at8  = rx_data;
        nrx_at8 = new_rx_data;
      end
      if (rises == 16) begin
        rx_at16  = rx_data;
        nrx_at16 = new_rx_data;
      end
    end
    if (!spi_ss) ss_low_cnt++;
    if (busy) busy_cnt++;
    if (frame_done) done_cnt++;
    if (new_rx_data) nrx_cnt++;
    if (spi_ss && busy) gap_cnt++;
    if (spi_ss && !prev_ss && rises == 16) dec_pulses++;
    spi_miso = (rises < 16) ? miso_pat[15 - rises] : 1'b0;
    prev_sck = spi_sck;
    prev_ss  = spi_ss;
  endtask

  // Presents a request on the current falling edge and runs until busy reads 0.
  // drop_at > 0 also pulses a 10'h001 request during that cycle of the frame.
  task automatic run_frame(input logic [9:0] s, input logic [3:0] ch, input int drop_at);
    int guard;
    clear_mon();
    sample         = s;
    sample_channel = ch;
    new_sample     = 1'b1;
    step();
    new_sample = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_ss", spi_ss, 0);
    guard = 0;
    while (busy && guard < 400) begin
      if (drop_at > 0 && guard == drop_at - 2) begin
        sample     = 10'h001;
        new_sample = 1'b1;
      end else begin
        new_sample = 1'b0;
      end
      step();
      guard++;
    end
    new_sample = 1'b0;
    chk("frame_end_busy", busy, 0);
  endtask

  initial begin
    clear_mon();

    // reset values
    step();
    step();
    chk("rst_ss", spi_ss, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_new_rx", new_rx_data, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    step();
    step();

    // basic frame 10'h2A5 ch 3 with MISO returning 5C, E1
    clear_mon();
    sample         = 10'h2A5;
    sample_channel = 4'h3;
    new_sample     = 1'b1;
    step();
    new_sample = 1'b0;
    chk("a_first_mosi", spi_mosi, 1);
    chk("a_first_busy", busy, 1);
    while (busy && busy_cnt < 400) step();
    chk("a_mosi_bytes", mosi_bits, 16'hA532);
    chk("a_rises", rises, 16);
    chk("a_ss_low", ss_low_cnt, 136);
    chk("a_busy_cycles", busy_cnt, 144);
    chk("a_frame_done", done_cnt, 1);
    chk("a_rx8_data", rx_at8, 8'h5C);
    chk("a_rx8_pulse", nrx_at8, 1);
    chk("a_rx16_data", rx_at16, 8'hE1);
    chk("a_rx16_pulse", nrx_at16, 1);
    chk("a_rx_pulses", nrx_cnt, 2);
    step();
    step();
    chk("a_rx_hold", rx_data, 8'hE1);

    // request during a frame is dropped
    run_frame(10'h155, 4'hA, 10);
    chk("d_mosi_bytes", mosi_bits, 16'h55A1);
    chk("d_frame_done", done_cnt, 1);
    chk("d_busy_cycles", busy_cnt, 144);
    for (int i = 0; i < 6; i++) step();
    chk("d_no_late_frame", busy, 0);
    chk("d_done_total", done_cnt, 1);

    // back-to-back: second request presented the cycle busy reads 0
    run_frame(10'h0F0, 4'h5, 0);
    chk("b1_mosi_bytes", mosi_bits, 16'hF050);
    chk("b1_gap_cycles", gap_cnt, 8);
    run_frame(10'h30C, 4'h9, 0);
    chk("b2_mosi_bytes", mosi_bits, 16'h0C93);
    chk("b2_ss_low", ss_low_cnt, 136);
    chk("b2_gap_cycles", gap_cnt, 8);

    // asynchronous reset after the 5th SCK rise
    clear_mon();
    sample         = 10'h2A5;
    sample_channel = 4'h3;
    new_sample     = 1'b1;
    step();
    new_sample = 1'b0;
    while (rises < 5 && busy_cnt < 400) step();
    chk("r_reached_rise5", rises, 5);
    chk("r_sck_high", spi_sck, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_ss", spi_ss, 1);
    chk("r_async_sck", spi_sck, 0);
    chk("r_async_busy", busy, 0);
    chk("r_async_done", frame_done, 0);
    chk("r_async_rx", rx_data, 8'h00);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("r_no_frame_done", done_cnt, 0);
    chk("r_idle_ss", spi_ss, 1);
    run_frame(10'h2A5, 4'h3, 0);
    chk("r_clean_mosi", mosi_bits, 16'hA532);
    chk("r_clean_ss_low", ss_low_cnt, 136);
    chk("r_clean_done", done_cnt, 1);

    // loopback into the AVR-side decoder model
    run_frame(10'h3FF, 4'hF, 0);
    chk("l_dec_sample", {mosi_bits[1:0], mosi_bits[15:8]}, 10'h3FF);
    chk("l_dec_channel", mosi_bits[7:4], 4'hF);
    chk("l_dec_pulses", dec_pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
